// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Central stall/flush controller for a 5-stage F/D/E/M/W pipeline.
//   It detects load-use hazards, taken-branch redirects and multi-cycle
//   data-memory waits, and drives the per-stage stall/flush enables
//   combinationally, so the response lands in the same cycle. A memory wait
//   that runs too long is latched as a sticky timeout error. Two saturating
//   counters record stall cycles and flush cycles.
//
// Parameters
//   TIMEOUT : max consecutive memory-wait cycles before ERROR (2..255)
//   CNT_W   : width of the statistics counters
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   rs1_D, rs2_D        : source registers of the instruction in Decode
//   rd_E, memRead_E     : destination / is-load of the instruction in Execute
//   branchTaken_E       : branch/jump resolved taken in Execute
//   mem_req_M           : Memory stage has an active data access
//   mem_ready_M         : data memory completes the access this cycle
//   stall_F..stall_M    : hold PC / F/D / D/E / E/M registers
//   flush_D, flush_E    : turn F/D / D/E contents into bubbles
//   mem_timeout         : sticky memory-wait timeout error
//   stall_cycles        : cycles with stall_F=1 (saturating)
//   flush_events        : cycles with flush_D or flush_E (saturating)
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       rs1_D,
   input  logic [4:0]       rs2_D,
   input  logic [4:0]       rd_E,
   input  logic             memRead_E,
   input  logic             branchTaken_E,
   input  logic             mem_req_M,
   input  logic             mem_ready_M,
   output logic             stall_F,
   output logic             stall_D,
   output logic             stall_E,
   output logic             stall_M,
   output logic             flush_D,
   output logic             flush_E,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

   // Last wait-count value tolerated before the wait is declared hung.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t     state, state_nxt;
   logic [7:0] wait_cnt, wait_cnt_nxt;
   logic       load_use, mem_wait;

   // A load writing x0 never creates a real dependency.
   assign load_use = memRead_E && (rd_E != 5'd0) && ((rd_E == rs1_D) || (rd_E == rs2_D));
   assign mem_wait = mem_req_M && !mem_ready_M;

   // NOTE: every output of this block gets a default before the case, so no
   //       path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      stall_F      = 1'b0;
      stall_D      = 1'b0;
      stall_E      = 1'b0;
      stall_M      = 1'b0;
      flush_D      = 1'b0;
      flush_E      = 1'b0;

      case (state)
         RUN: begin
            // Priority: memory wait freezes everything, then redirect, then load-use.
            if (mem_wait) begin
               {stall_F, stall_D, stall_E, stall_M} = 4'b1111;
               wait_cnt_nxt = 8'd1;
               state_nxt    = MEM_WAIT;
            end else if (branchTaken_E) begin
               flush_D = 1'b1;
               flush_E = 1'b1;
            end else if (load_use) begin
               // Hold F and D, inject a bubble into E; the hazard is gone next cycle.
               stall_F = 1'b1;
               stall_D = 1'b1;
               flush_E = 1'b1;
            end
         end
         MEM_WAIT: begin
            // Branch/load-use are frozen here and re-evaluated once back in RUN.
            if (mem_ready_M) begin
               wait_cnt_nxt = 8'd0;
               state_nxt    = RUN;
            end else begin
               {stall_F, stall_D, stall_E, stall_M} = 4'b1111;
               wait_cnt_nxt = wait_cnt + 8'd1;
               if (wait_cnt == WAIT_LAST) state_nxt = ERROR;
            end
         end
         ERROR: begin
            {stall_F, stall_D, stall_E, stall_M} = 4'b1111;
         end
         default: state_nxt = RUN;
      endcase

      if (reset) begin
         {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E} = 6'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   //       samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= RUN;
         wait_cnt     <= 8'd0;
         mem_timeout  <= 1'b0;
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (state_nxt == ERROR) mem_timeout <= 1'b1;
         // Counters saturate at all-ones rather than wrapping.
         if (stall_F && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
         if ((flush_D || flush_E) && (flush_events != '1)) flush_events <= flush_events + 1'b1;
      end
   end

endmodule
